// File: rtl/jtag_bpr.sv
// jtag_bpr: JTAG BYPASS (1 bit) and IDCODE (ID_WIDTH bits) data registers
// sharing one TAP-facing signal group. The fields of the bprif bundle are
// carried as flat ports named after the bundle members.
module jtag_bpr #(
    parameter int                ID_WIDTH = 32,
    parameter logic [ID_WIDTH-1:0] IDCODE = 32'h1000_1003
) (
    input  logic                TCK,
    input  logic                TRST,
    input  logic                tdi,
    input  logic                shift_dr,
    input  logic                capture_dr,
    input  logic                bypass_sel,
    output logic                tdo,
    output logic [ID_WIDTH-1:0] code,
    output logic                bypass_q
);

    logic [ID_WIDTH-1:0] code_d, code_q;
    logic                byp_d, byp_q;

    // ID register: shifts toward tdo when selected, otherwise reloads the ID
    // every cycle, so capture and idle behave identically.
    always_comb begin
        code_d = IDCODE;
        if (shift_dr && !bypass_sel) begin
            code_d = {tdi, code_q[ID_WIDTH-1:1]};
        end
    end

    // BYPASS flop: shift takes priority over capture; otherwise it holds.
    always_comb begin
        byp_d = byp_q;
        if (shift_dr && bypass_sel) begin
            byp_d = tdi;
        end else if (capture_dr) begin
            byp_d = 1'b0;
        end
    end

    // State registers with synchronous active-high reset.
    always_ff @(posedge TCK) begin
        if (TRST) begin
            code_q <= '0;
            byp_q  <= 1'b0;
        end else begin
            code_q <= code_d;
            byp_q  <= byp_d;
        end
    end

    // Serial output is a plain mux of the register LSBs, no output stage.
    always_comb begin
        tdo = bypass_sel ? byp_q : code_q[0];
    end

    assign code     = code_q;
    assign bypass_q = byp_q;

endmodule

// File: tb/tb_jtag_bpr.sv
// Self-checking bench for jtag_bpr: directed scenarios plus randomized
// stimulus compared against a behavioural model of the two registers.
module tb_jtag_bpr;

    localparam logic [31:0] ID = 32'h1000_1003;

    logic        TCK = 1'b0;
    logic        TRST;
    logic        tdi;
    logic        shift_dr;
    logic        capture_dr;
    logic        bypass_sel;
    logic        tdo;
    logic [31:0] code;
    logic        bypass_q;

    int unsigned passed = 0;
    int unsigned total  = 0;

    // Behavioural model state
    logic [31:0] m_code = '0;
    logic        m_byp  = 1'b0;

    jtag_bpr #(.ID_WIDTH(32), .IDCODE(ID)) dut (
        .TCK        (TCK),
        .TRST       (TRST),
        .tdi        (tdi),
        .shift_dr   (shift_dr),
        .capture_dr (capture_dr),
        .bypass_sel (bypass_sel),
        .tdo        (tdo),
        .code       (code),
        .bypass_q   (bypass_q)
    );

    always #5 TCK = ~TCK;

    // Advance the model by the rules for the current inputs, then let the DUT
    // take the same rising edge and settle.
    task automatic tick();
        if (TRST) begin
            m_code = 32'd0;
            m_byp  = 1'b0;
        end else begin
            if (shift_dr && !bypass_sel)
                m_code = (m_code >> 1) + (tdi ? 32'h8000_0000 : 32'd0);
            else
                m_code = ID;
            if (shift_dr && bypass_sel)
                m_byp = tdi;
            else if (capture_dr)
                m_byp = 1'b0;
        end
        @(posedge TCK);
        #1;
    endtask

    task automatic idle_inputs();
        TRST = 0; tdi = 0; shift_dr = 0; capture_dr = 0; bypass_sel = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        TRST = 1; shift_dr = 1; capture_dr = 1; tdi = 1;
        tick();
        tick();
        total++; if (code !== 32'd0) $display("FAIL reset_code got=%h exp=%h", code, 32'd0); else passed++;
        total++; if (bypass_q !== 1'b0) $display("FAIL reset_bypass got=%b exp=0", bypass_q); else passed++;
        total++; if (tdo !== 1'b0) $display("FAIL reset_tdo got=%b exp=0", tdo); else passed++;
    endtask

    task automatic test_id_load();
        idle_inputs();
        tick();
        tick();
        total++; if (code !== 32'h1000_1003) $display("FAIL load_code got=%h exp=%h", code, 32'h1000_1003); else passed++;
        total++; if (tdo !== 1'b1) $display("FAIL load_tdo got=%b exp=1", tdo); else passed++;
    endtask

    task automatic test_id_shift_out();
        logic [31:0] idv;
        int unsigned errs;
        idv = 32'h1000_1003;
        errs = 0;
        bypass_sel = 0; shift_dr = 1; tdi = 0;
        for (int i = 0; i < 32; i++) begin
            total++;
            if (tdo !== idv[i]) begin
                $display("FAIL shift_tdo bit=%0d got=%b exp=%b", i, tdo, idv[i]);
                errs++;
            end else passed++;
            tick();
        end
        total++; if (code !== 32'd0) $display("FAIL shift_final_code got=%h exp=0", code); else passed++;
        shift_dr = 0;
    endtask

    task automatic test_bypass();
        logic [2:0] pat;
        idle_inputs();
        capture_dr = 1;
        tick();
        total++; if (bypass_q !== 1'b0) $display("FAIL byp_capture got=%b exp=0", bypass_q); else passed++;
        capture_dr = 0;
        bypass_sel = 1; shift_dr = 1;
        pat = 3'b101;
        for (int i = 2; i >= 0; i--) begin
            tdi = pat[i];
            tick();
            total++; if (tdo !== pat[i]) $display("FAIL byp_tdo step=%0d got=%b exp=%b", 2 - i, tdo, pat[i]); else passed++;
            total++; if (code !== 32'h1000_1003) $display("FAIL byp_code_unaffected got=%h exp=%h", code, 32'h1000_1003); else passed++;
        end
        idle_inputs();
    endtask

    task automatic test_reset_mid_shift();
        idle_inputs();
        tick();
        shift_dr = 1;
        for (int i = 0; i < 5; i++) begin
            tdi = 1'($urandom_range(0, 1));
            tick();
        end
        TRST = 1;
        tick();
        total++; if (code !== 32'd0) $display("FAIL midrst_code got=%h exp=0", code); else passed++;
        total++; if (tdo !== 1'b0) $display("FAIL midrst_tdo got=%b exp=0", tdo); else passed++;
        TRST = 0; shift_dr = 0;
        tick();
        total++; if (code !== 32'h1000_1003) $display("FAIL midrst_reload got=%h exp=%h", code, 32'h1000_1003); else passed++;
    endtask

    task automatic test_priority();
        idle_inputs();
        tick();
        shift_dr = 1; capture_dr = 1; tdi = 1; bypass_sel = 0;
        tick();
        total++; if (code !== 32'h8800_0801) $display("FAIL prio_id got=%h exp=%h", code, 32'h8800_0801); else passed++;
        bypass_sel = 1;
        tick();
        total++; if (bypass_q !== 1'b1) $display("FAIL prio_byp got=%b exp=1", bypass_q); else passed++;
        idle_inputs();
    endtask

    task automatic test_random();
        logic exp_tdo;
        for (int n = 0; n < 300; n++) begin
            TRST       = ($urandom_range(0, 15) == 0);
            tdi        = 1'($urandom_range(0, 1));
            shift_dr   = ($urandom_range(0, 3) != 0);
            capture_dr = ($urandom_range(0, 3) == 0);
            bypass_sel = 1'($urandom_range(0, 1));
            tick();
            total++; if (code !== m_code) $display("FAIL rnd_code n=%0d got=%h exp=%h", n, code, m_code); else passed++;
            total++; if (bypass_q !== m_byp) $display("FAIL rnd_byp n=%0d got=%b exp=%b", n, bypass_q, m_byp); else passed++;
            bypass_sel = ~bypass_sel;
            #1;
            exp_tdo = bypass_sel ? m_byp : m_code[0];
            total++; if (tdo !== exp_tdo) $display("FAIL rnd_tdo n=%0d got=%b exp=%b", n, tdo, exp_tdo); else passed++;
        end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        @(negedge TCK);
        test_reset();
        test_id_load();
        test_id_shift_out();
        test_bypass();
        test_reset_mid_shift();
        test_priority();
        test_reset();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout passed=%0d total=%0d", passed, total);
        $fatal(1, "timeout");
    end

endmodule
